// File: rtl/seg7_scan.sv
// Multiplexed four-digit seven-segment driver with blank guard time between digits.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan #(
    parameter int GUARD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [1:0]  digit_sel,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        state_dbg
);

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] frame_val_q, frame_val_d;
    logic [3:0]  frame_dp_q, frame_dp_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic [15:0] src_val;
    logic [3:0]  src_dp;
    logic [3:0]  nib;
`ifdef SEG7_SCAN_LZB_EN
    logic        lzb_blank;
`endif

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'b1000000;
            4'h1: p = 7'b1111001;
            4'h2: p = 7'b0100100;
            4'h3: p = 7'b0110000;
            4'h4: p = 7'b0011001;
            4'h5: p = 7'b0010010;
            4'h6: p = 7'b0000010;
            4'h7: p = 7'b1111000;
            4'h8: p = 7'b0000000;
            4'h9: p = 7'b0010000;
            4'hA: p = 7'b0001000;
            4'hB: p = 7'b0000011;
            4'hC: p = 7'b1000110;
            4'hD: p = 7'b0100001;
            4'hE: p = 7'b0000110;
            default: p = 7'b0001110;
        endcase
        return p;
    endfunction

    // Digit 0 opens a new frame, so it decodes straight from the inputs being latched.
    always_comb begin
        src_val = (digit_sel == 2'd0) ? value : frame_val_q;
        src_dp  = (digit_sel == 2'd0) ? dp_in : frame_dp_q;
        nib     = src_val[{digit_sel, 2'b00} +: 4];
`ifdef SEG7_SCAN_LZB_EN
        case (digit_sel)
            2'd1:    lzb_blank = (src_val[15:4]  == 12'd0) && !src_dp[1];
            2'd2:    lzb_blank = (src_val[15:8]  == 8'd0)  && !src_dp[2];
            2'd3:    lzb_blank = (src_val[15:12] == 4'd0)  && !src_dp[3];
            default: lzb_blank = 1'b0;
        endcase
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_val_d = frame_val_q;
        frame_dp_d  = frame_dp_q;
        an_d        = an_q;
        seg_d       = seg_q;
        dp_d        = dp_q;
        case (state_q)
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = SHOW;
                    if (digit_sel == 2'd0) begin
                        frame_val_d = value;
                        frame_dp_d  = dp_in;
                    end
                    an_d  = ~(4'b0001 << digit_sel);
                    seg_d = hex_decode(nib);
                    dp_d  = ~src_dp[digit_sel];
`ifdef SEG7_SCAN_LZB_EN
                    if (lzb_blank) begin
                        an_d  = 4'hF;
                        seg_d = 7'h7F;
                        dp_d  = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                // Blanking on the ce edge guarantees no two anodes are ever low together.
                if (ce) begin
                    state_d = GUARD;
                    cnt_d   = 8'd0;
                    an_d    = 4'hF;
                    seg_d   = 7'h7F;
                    dp_d    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= GUARD;
            cnt_q       <= 8'd0;
            frame_val_q <= 16'd0;
            frame_dp_q  <= 4'd0;
            an_q        <= 4'hF;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_val_q <= frame_val_d;
            frame_dp_q  <= frame_dp_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: one instance with four guard cycles, one with none.
// Expected {an,seg,dp} words are queued when a digit is requested and popped when it appears.
module tb_seg7_scan;

    localparam int G4 = 4;
    localparam int G0 = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce4, ce0;
    logic [1:0]  sel4, sel0;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  an4, an0;
    logic [6:0]  seg4, seg0;
    logic        dp4, dp0, st4, st0;

    logic [11:0] exp_q[$];
    logic [15:0] m_val[2];
    logic [3:0]  m_dp[2];
    int          checks = 0;
    int          failures = 0;

    seg7_scan #(.GUARD_CYCLES(G4)) dut4 (
        .clk(clk), .rst(rst), .ce(ce4), .digit_sel(sel4), .value(value), .dp_in(dp_in),
        .an(an4), .seg(seg4), .dp(dp4), .state_dbg(st4)
    );

    seg7_scan #(.GUARD_CYCLES(G0)) dut0 (
        .clk(clk), .rst(rst), .ce(ce0), .digit_sel(sel0), .value(value), .dp_in(dp_in),
        .an(an0), .seg(seg0), .dp(dp0), .state_dbg(st0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [11:0] model(input int w, input logic [1:0] s);
        logic [15:0] upper;
        logic [3:0]  nib;
        logic [3:0]  one_hot;
        logic        blank;
        upper   = m_val[w] >> (4 * s);
        nib     = upper[3:0];
        one_hot = 4'b0001 << s;
        blank   = 1'b0;
`ifdef SEG7_SCAN_LZB_EN
        if (s != 2'd0 && upper == 16'd0 && !m_dp[w][s]) blank = 1'b1;
`endif
        if (blank) return 12'hFFF;
        return {~one_hot, dec(nib), ~m_dp[w][s]};
    endfunction

    function automatic logic [11:0] obs(input int w);
        return (w == 0) ? {an4, seg4, dp4} : {an0, seg0, dp0};
    endfunction

    task automatic check(input string tag, input logic [11:0] o, input logic [11:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic set_ce(input int w, input logic v);
        if (w == 0) ce4 = v;
        else ce0 = v;
    endtask

    // Expects nb blank samples (one per negedge), then pops and compares the shown digit.
    task automatic show_after(input int w, input int nb, input int extra, input string tag);
        logic blank_ok;
        blank_ok = 1'b1;
        for (int i = 0; i < nb; i++) begin
            if (obs(w) !== 12'hFFF) blank_ok = 1'b0;
            set_ce(w, i == extra);
            @(negedge clk);
        end
        set_ce(w, 1'b0);
        check({tag, "_guard"}, {11'd0, blank_ok}, 12'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 12'd0, 12'd1);
        end else begin
            check(tag, obs(w), exp_q.pop_front());
        end
    endtask

    task automatic step(input int w, input logic [1:0] s, input int extra, input string tag);
        if (w == 0) sel4 = s;
        else sel0 = s;
        if (s == 2'd0) begin
            m_val[w] = value;
            m_dp[w]  = dp_in;
        end
        exp_q.push_back(model(w, s));
        set_ce(w, 1'b1);
        @(negedge clk);
        set_ce(w, 1'b0);
        show_after(w, ((w == 0) ? G4 : G0) + 1, extra, tag);
    endtask

    task automatic frame(input int w, input logic [15:0] v, input string tag);
        value = v;
        for (int d = 0; d < 4; d++) step(w, 2'(d), -1, tag);
    endtask

    initial begin
        rst   = 1'b0;
        ce4   = 1'b0;
        ce0   = 1'b0;
        sel4  = 2'd0;
        sel0  = 2'd0;
        value = 16'h0123;
        dp_in = 4'd0;
        m_val[0] = 16'd0; m_val[1] = 16'd0;
        m_dp[0]  = 4'd0;  m_dp[1]  = 4'd0;

        @(negedge clk);
        check("reset_out4", obs(0), 12'hFFF);
        check("reset_out0", obs(1), 12'hFFF);
        check("reset_state", {10'd0, st4, st0}, 12'd0);

        rst = 1'b1;
        m_val[0] = value;
        m_dp[0]  = dp_in;
        exp_q.push_back(model(0, 2'd0));
        @(negedge clk);
        show_after(0, G4, -1, "rst_release");
        check("show_state", {11'd0, st4}, 12'd1);

        for (int d = 1; d < 4; d++) step(0, 2'(d), -1, "sweep_0123");
        frame(0, 16'h4567, "sweep_4567");
        frame(0, 16'h89AB, "sweep_89AB");
        frame(0, 16'hCDEF, "sweep_CDEF");

        dp_in = 4'b1010;
        value = 16'h1234;
        step(0, 2'd0, -1, "tear_d0");
        step(0, 2'd1, -1, "tear_d1");
        step(0, 2'd2, -1, "tear_d2");
        value = 16'h5678;
        step(0, 2'd3, -1, "tear_d3");
        frame(0, 16'h5678, "tear_next");

        step(0, 2'd0, 1, "ce_in_guard");
        step(0, 2'd1, 3, "ce_in_guard_late");

        #2 rst = 1'b0;
        #1;
        check("rst_mid_out4", obs(0), 12'hFFF);
        check("rst_mid_out0", obs(1), 12'hFFF);
        check("rst_mid_state", {11'd0, st4}, 12'd0);
        m_val[0] = 16'd0; m_val[1] = 16'd0;
        m_dp[0]  = 4'd0;  m_dp[1]  = 4'd0;
        @(negedge clk);
        rst  = 1'b1;
        sel4 = 2'd2;
        exp_q.push_back(model(0, 2'd2));
        @(negedge clk);
        show_after(0, G4, -1, "rst_mid_release");

        dp_in = 4'd0;
        frame(0, 16'h0005, "lzb_0005");

        dp_in = 4'b0100;
        frame(1, 16'h0005, "g0_dp");
        frame(1, 16'h9E70, "g0_9E70");
        dp_in = 4'b0000;
        frame(1, 16'h0A00, "g0_0A00");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter GUARD_CYCLES, default 4, number of all-digits-off clock cycles inserted between digits (anti-ghosting); legal range 0..255.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 ce  input  1  scan-advance strobe, one clk wide; same strobe that advances the upstream 2-bit digit counter.
REQ-005 digit_sel  input  2  current digit index from the upstream 2-bit counter (0 = rightmost).
REQ-006 value  input  16  hex value to display; nibble n shown on digit n.
REQ-007 dp_in  input  4  decimal-point request per digit, active-high.
REQ-008 an  output  4  digit anodes, active-low, registered.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 dp  output  1  decimal point, active-low, registered.

Function
REQ-011 The block SHALL implement a two-state FSM: SHOW and GUARD, plus an 8-bit guard counter.
REQ-012 In SHOW, an SHALL have exactly one bit low (bit = captured digit index); seg/dp SHALL hold the captured digit pattern.
REQ-013 ce=1 in SHOW SHALL, on that edge, force an=4'b1111, seg=7'h7F, dp=1, load guard counter with 0, enter GUARD.
REQ-014 In GUARD, the counter SHALL increment each cycle; when counter == GUARD_CYCLES, the block SHALL capture digit_sel, decode, drive outputs and enter SHOW on that edge.
REQ-015 With GUARD_CYCLES=0, first displayed pattern SHALL appear on the edge after the ce edge (digit_sel already updated upstream).
REQ-016 ce asserted during GUARD SHALL be ignored; counter is not restarted.
REQ-017 Value snapshot: when captured digit_sel == 0, value and dp_in SHALL be latched into a frame register; digits 1..3 SHALL be decoded from the frame register (no tearing within a frame).
REQ-018 Decode SHALL be standard hex, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 dp SHALL equal ~frame_dp[digit] while in SHOW, 1 otherwise.
REQ-020 No output SHALL ever have two anodes low simultaneously, including at state transitions.

Reset
REQ-021 rst=0 SHALL immediately (asynchronously) force an=4'b1111, seg=7'h7F, dp=1, state=GUARD, guard counter=0, frame register=0.
REQ-022 After rst release, the block SHALL complete a normal GUARD period and then capture digit_sel; reset mid-digit SHALL blank instantly with no partial pattern.

Configuration
REQ-023 Macro SEG7_SCAN_LZB_EN: defined -> leading-zero blanking: digit n (n=3..1) SHALL show seg=7'h7F, an bit high, when frame nibbles n..3 are all zero and frame_dp[n]=0; digit 0 always shown.
REQ-024 Macro SEG7_SCAN_LZB_EN undefined -> all four digits SHALL always be displayed, including leading zeros; no blanking logic is synthesized.

Verification
REQ-025 Reset: rst=0 mid-SHOW -> an=1111, seg=7F, dp=1 before next clk edge; release -> first digit after GUARD_CYCLES+1 edges.
REQ-026 Decode sweep: value=16'h0123..16'hCDEF over frames, GUARD_CYCLES=4 -> each digit's seg matches REQ-018 table, exactly GUARD_CYCLES+1 blank cycles after each ce.
REQ-027 Tearing: change value from 16'h1234 to 16'h5678 while digit 2 displayed -> digit 3 shows 1; next frame shows 5678.
REQ-028 ce during GUARD, GUARD_CYCLES=4: second ce 2 cycles after first -> SHOW entered 5 edges after first ce, not extended.
REQ-029 GUARD_CYCLES=0, dp_in=4'b0100 -> pattern one edge after ce; dp=0 only while an=1011.
REQ-030 With SEG7_SCAN_LZB_EN, value=16'h0005 -> digits 3..1 an bits stay high, digit 0 shows 0010010; without macro -> digits 3..1 show 1000000.
